// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: resolves conditional branches, JAL and JALR in execute.
// The result is registered behind a valid/ready handshake. A 2-bit saturating
// branch history table gives fetch its direction predictions.
// Optional feature: define BRU_STATS_EN to enable the saturating statistics
// counters. When the macro is undefined, stat_branches_o and stat_mispred_o are 0.
module branch_resolve_unit #(
  parameter int         N         = 32,
  parameter int         BHT_DEPTH = 64,
  parameter logic [1:0] BHT_INIT  = 2'b01
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush_i,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic         is_branch_i,
  input  logic         is_jal_i,
  input  logic         is_jalr_i,
  input  logic [2:0]   funct3_i,
  input  logic [N-1:0] data1_i,
  input  logic [N-1:0] data2_i,
  input  logic [N-1:0] pc_i,
  input  logic [N-1:0] imm_i,
  input  logic         pred_taken_i,
  input  logic [N-1:0] pred_target_i,
  input  logic [N-1:0] lookup_pc_i,
  output logic         pred_taken_o,
  output logic         valid_o,
  input  logic         ready_i,
  output logic         taken_o,
  output logic [N-1:0] target_o,
  output logic         mispredict_o,
  output logic [N-1:0] redirect_pc_o,
  output logic         illegal_o,
  output logic [31:0]  stat_branches_o,
  output logic [31:0]  stat_mispred_o
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic valid_q, valid_d;
  logic accept;
  logic fire;

  assign ready_o = ~valid_q | ready_i;
  assign accept  = valid_i & ready_o & ~flush_i;
  assign fire    = valid_q & ready_i;

  // ---------------------------------------------------------------------------
  // Condition evaluation: full-width signed and unsigned compares
  // ---------------------------------------------------------------------------
  logic cmp_eq, cmp_lt_s, cmp_lt_u;
  logic cond_true;
  logic bad_funct3;

  assign cmp_eq   = (data1_i == data2_i);
  assign cmp_lt_s = ($signed(data1_i) < $signed(data2_i));
  assign cmp_lt_u = (data1_i < data2_i);

  // Decode funct3 into a branch outcome; codes 2 and 3 are reserved
  always_comb begin
    cond_true  = 1'b0;
    bad_funct3 = 1'b0;
    case (funct3_i)
      3'd0:    cond_true = cmp_eq;
      3'd1:    cond_true = ~cmp_eq;
      3'd4:    cond_true = cmp_lt_s;
      3'd5:    cond_true = ~cmp_lt_s;
      3'd6:    cond_true = cmp_lt_u;
      3'd7:    cond_true = ~cmp_lt_u;
      default: bad_funct3 = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Resolution: JALR > JAL > branch > nothing
  // ---------------------------------------------------------------------------
  logic [N-1:0] pc_imm;
  logic [N-1:0] jalr_sum;
  logic [N-1:0] pc_plus4;
  logic         res_taken;
  logic [N-1:0] res_target;
  logic         res_illegal;
  logic         res_cond_branch;
  logic [N-1:0] res_redirect;
  logic         res_mispredict;

  assign pc_imm   = pc_i + imm_i;
  assign jalr_sum = data1_i + imm_i;
  assign pc_plus4 = pc_i + N'(4);

  // Pick direction and target for the instruction class that wins priority
  always_comb begin
    res_taken       = 1'b0;
    res_target      = pc_imm;
    res_illegal     = 1'b0;
    res_cond_branch = 1'b0;
    if (is_jalr_i) begin
      res_taken  = 1'b1;
      res_target = {jalr_sum[N-1:1], 1'b0};
    end else if (is_jal_i) begin
      res_taken  = 1'b1;
    end else if (is_branch_i) begin
      res_taken       = cond_true & ~bad_funct3;
      res_illegal     = bad_funct3;
      res_cond_branch = ~bad_funct3;
    end
  end

  assign res_redirect   = res_taken ? res_target : pc_plus4;
  assign res_mispredict = (res_taken != pred_taken_i) |
                          (res_taken & (res_target != pred_target_i));

  // ---------------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------------
  logic         taken_q, taken_d;
  logic [N-1:0] target_q, target_d;
  logic         mispredict_q, mispredict_d;
  logic [N-1:0] redirect_q, redirect_d;
  logic         illegal_q, illegal_d;

  // Next state of the result stage: flush drops, accept loads, fire empties
  always_comb begin
    valid_d      = valid_q;
    taken_d      = taken_q;
    target_d     = target_q;
    mispredict_d = mispredict_q;
    redirect_d   = redirect_q;
    illegal_d    = illegal_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d      = 1'b1;
      taken_d      = res_taken;
      target_d     = res_target;
      mispredict_d = res_mispredict;
      redirect_d   = res_redirect;
      illegal_d    = res_illegal;
    end else if (fire) begin
      valid_d = 1'b0;
    end
  end

  // Result stage registers, cleared by reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q      <= 1'b0;
      taken_q      <= 1'b0;
      target_q     <= '0;
      mispredict_q <= 1'b0;
      redirect_q   <= '0;
      illegal_q    <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      taken_q      <= taken_d;
      target_q     <= target_d;
      mispredict_q <= mispredict_d;
      redirect_q   <= redirect_d;
      illegal_q    <= illegal_d;
    end
  end

  assign valid_o       = valid_q;
  assign taken_o       = taken_q;
  assign target_o      = target_q;
  assign mispredict_o  = mispredict_q;
  assign redirect_pc_o = redirect_q;
  assign illegal_o     = illegal_q;

  // ---------------------------------------------------------------------------
  // Branch history table: flop array so every entry resets to BHT_INIT and the
  // fetch-side lookup can be read combinationally.
  // ---------------------------------------------------------------------------
  logic [1:0]       bht_q [BHT_DEPTH];
  logic [IDX_W-1:0] upd_idx;
  logic [IDX_W-1:0] lk_idx;
  logic [1:0]       upd_cnt;
  logic [1:0]       upd_cnt_d;
  logic             bht_we;
  logic             unused_pc_bits;

  assign upd_idx = pc_i[IDX_W+1:2];
  assign lk_idx  = lookup_pc_i[IDX_W+1:2];
  assign bht_we  = accept & res_cond_branch;
  assign upd_cnt = bht_q[upd_idx];

  // Lookup reads the registered counter, so a same-cycle update is not visible
  assign pred_taken_o = bht_q[lk_idx][1];

  assign unused_pc_bits = ^{lookup_pc_i[N-1:IDX_W+2], lookup_pc_i[1:0]};

  // Saturating increment on taken, decrement on not-taken
  always_comb begin
    upd_cnt_d = upd_cnt;
    if (res_taken) begin
      if (upd_cnt != 2'b11) upd_cnt_d = upd_cnt + 2'd1;
    end else begin
      if (upd_cnt != 2'b00) upd_cnt_d = upd_cnt - 2'd1;
    end
  end

  for (genvar gi = 0; gi < BHT_DEPTH; gi++) begin : g_bht
    // One counter per entry, written only by an accepted legal branch at its index
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        bht_q[gi] <= BHT_INIT;
      end else if (bht_we && (upd_idx == IDX_W'(gi))) begin
        bht_q[gi] <= upd_cnt_d;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Statistics
  // ---------------------------------------------------------------------------
`ifdef BRU_STATS_EN
  logic        cond_br_q;
  logic [31:0] stat_br_q;
  logic [31:0] stat_mp_q;

  // Remember whether the held result is a legal conditional branch
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cond_br_q <= 1'b0;
    end else if (accept) begin
      cond_br_q <= res_cond_branch;
    end
  end

  // Count results as they leave the unit; counters stick at all-ones
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else if (fire) begin
      if (cond_br_q && (stat_br_q != 32'hFFFF_FFFF)) stat_br_q <= stat_br_q + 32'd1;
      if (mispredict_q && (stat_mp_q != 32'hFFFF_FFFF)) stat_mp_q <= stat_mp_q + 32'd1;
    end
  end

  assign stat_branches_o = stat_br_q;
  assign stat_mispred_o  = stat_mp_q;
`else
  assign stat_branches_o = 32'd0;
  assign stat_mispred_o  = 32'd0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed testbench for branch_resolve_unit with hand-computed expectations.
module tb_branch_resolve_unit;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        flush_i = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic        is_branch_i = 1'b0;
  logic        is_jal_i = 1'b0;
  logic        is_jalr_i = 1'b0;
  logic [2:0]  funct3_i = 3'd0;
  logic [31:0] data1_i = '0;
  logic [31:0] data2_i = '0;
  logic [31:0] pc_i = '0;
  logic [31:0] imm_i = '0;
  logic        pred_taken_i = 1'b0;
  logic [31:0] pred_target_i = '0;
  logic [31:0] lookup_pc_i = '0;
  logic        pred_taken_o;
  logic        valid_o;
  logic        ready_i = 1'b1;
  logic        taken_o;
  logic [31:0] target_o;
  logic        mispredict_o;
  logic [31:0] redirect_pc_o;
  logic        illegal_o;
  logic [31:0] stat_branches_o;
  logic [31:0] stat_mispred_o;

  int n_checks = 0;
  int n_fail = 0;

  branch_resolve_unit #(.N(32), .BHT_DEPTH(64), .BHT_INIT(2'b01)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
    .is_branch_i(is_branch_i), .is_jal_i(is_jal_i), .is_jalr_i(is_jalr_i), .funct3_i(funct3_i),
    .data1_i(data1_i), .data2_i(data2_i), .pc_i(pc_i), .imm_i(imm_i),
    .pred_taken_i(pred_taken_i), .pred_target_i(pred_target_i), .lookup_pc_i(lookup_pc_i),
    .pred_taken_o(pred_taken_o), .valid_o(valid_o), .ready_i(ready_i), .taken_o(taken_o),
    .target_o(target_o), .mispredict_o(mispredict_o), .redirect_pc_o(redirect_pc_o),
    .illegal_o(illegal_o), .stat_branches_o(stat_branches_o), .stat_mispred_o(stat_mispred_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic b, input logic j, input logic jr, input logic [2:0] f3,
                       input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] pc,
                       input logic [31:0] imm, input logic pt, input logic [31:0] ptgt);
    valid_i = 1'b1; is_branch_i = b; is_jal_i = j; is_jalr_i = jr; funct3_i = f3;
    data1_i = d1; data2_i = d2; pc_i = pc; imm_i = imm; pred_taken_i = pt; pred_target_i = ptgt;
  endtask

  task automatic do_reset();
    valid_i = 1'b0; flush_i = 1'b0; ready_i = 1'b1; rst_i = 1'b1;
    step(); step();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    valid_i = 1'b0; rst_i = 1'b1; lookup_pc_i = 32'h40;
    step(); step();
    if (valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %0h want 0", valid_o); end n_checks++;
    if (taken_o !== 1'b0) begin n_fail++; $display("FAIL rst_taken: got %0h want 0", taken_o); end n_checks++;
    if (target_o !== 32'h0) begin n_fail++; $display("FAIL rst_target: got %08h want 0", target_o); end n_checks++;
    if (redirect_pc_o !== 32'h0) begin n_fail++; $display("FAIL rst_redirect: got %08h want 0", redirect_pc_o); end n_checks++;
    if (mispredict_o !== 1'b0) begin n_fail++; $display("FAIL rst_mispred: got %0h want 0", mispredict_o); end n_checks++;
    if (illegal_o !== 1'b0) begin n_fail++; $display("FAIL rst_illegal: got %0h want 0", illegal_o); end n_checks++;
    if (ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %0h want 1", ready_o); end n_checks++;
    if (pred_taken_o !== 1'b0) begin n_fail++; $display("FAIL rst_bht: got %0h want 0", pred_taken_o); end n_checks++;
    if (stat_branches_o !== 32'h0) begin n_fail++; $display("FAIL rst_stat_br: got %0h want 0", stat_branches_o); end n_checks++;
    if (stat_mispred_o !== 32'h0) begin n_fail++; $display("FAIL rst_stat_mp: got %0h want 0", stat_mispred_o); end n_checks++;
    rst_i = 1'b0;
    $display("reset: valid=%0h ready=%0h pred=%0h", valid_o, ready_o, pred_taken_o);
  endtask

  task automatic test_branch_cond();
    // BLT signed: -1 < 1
    drive(1, 0, 0, 3'd4, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1'b0, 32'h0);
    step(); valid_i = 1'b0;
    if (valid_o !== 1'b1) begin n_fail++; $display("FAIL blt_valid: got %0h want 1", valid_o); end n_checks++;
    if (taken_o !== 1'b1) begin n_fail++; $display("FAIL blt_taken: got %0h want 1", taken_o); end n_checks++;
    if (target_o !== 32'h120) begin n_fail++; $display("FAIL blt_target: got %08h want 00000120", target_o); end n_checks++;
    if (mispredict_o !== 1'b1) begin n_fail++; $display("FAIL blt_mispred: got %0h want 1", mispredict_o); end n_checks++;
    if (redirect_pc_o !== 32'h120) begin n_fail++; $display("FAIL blt_redirect: got %08h want 00000120", redirect_pc_o); end n_checks++;
    $display("blt: taken=%0h target=%08h mispred=%0h redirect=%08h", taken_o, target_o, mispredict_o, redirect_pc_o);
    // BLTU with the same operands: 0xFFFFFFFF is not below 1
    drive(1, 0, 0, 3'd6, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1'b0, 32'h0);
    step(); valid_i = 1'b0;
    if (taken_o !== 1'b0) begin n_fail++; $display("FAIL bltu_taken: got %0h want 0", taken_o); end n_checks++;
    if (redirect_pc_o !== 32'h104) begin n_fail++; $display("FAIL bltu_redirect: got %08h want 00000104", redirect_pc_o); end n_checks++;
    if (mispredict_o !== 1'b0) begin n_fail++; $display("FAIL bltu_mispred: got %0h want 0", mispredict_o); end n_checks++;
    $display("bltu: taken=%0h redirect=%08h mispred=%0h", taken_o, redirect_pc_o, mispredict_o);
    // BGE signed: 0x80000000 >= 0 is false
    drive(1, 0, 0, 3'd5, 32'h8000_0000, 32'h0, 32'h108, 32'h40, 1'b1, 32'h148);
    step(); valid_i = 1'b0;
    if (taken_o !== 1'b0) begin n_fail++; $display("FAIL bge_taken: got %0h want 0", taken_o); end n_checks++;
    if (mispredict_o !== 1'b1) begin n_fail++; $display("FAIL bge_mispred: got %0h want 1", mispredict_o); end n_checks++;
    $display("bge: taken=%0h mispred=%0h", taken_o, mispredict_o);
    // BGEU: 0x80000000 >= 0 is true
    drive(1, 0, 0, 3'd7, 32'h8000_0000, 32'h0, 32'h108, 32'h40, 1'b1, 32'h148);
    step(); valid_i = 1'b0;
    if (taken_o !== 1'b1) begin n_fail++; $display("FAIL bgeu_taken: got %0h want 1", taken_o); end n_checks++;
    if (mispredict_o !== 1'b0) begin n_fail++; $display("FAIL bgeu_mispred: got %0h want 0", mispredict_o); end n_checks++;
    $display("bgeu: taken=%0h mispred=%0h", taken_o, mispredict_o);
    // BNE on equal operands is not taken
    drive(1, 0, 0, 3'd1, 32'h55, 32'h55, 32'h10C, 32'h8, 1'b0, 32'h0);
    step(); valid_i = 1'b0;
    if (taken_o !== 1'b0) begin n_fail++; $display("FAIL bne_taken: got %0h want 0", taken_o); end n_checks++;
    $display("bne: taken=%0h", taken_o);
  endtask

  task automatic test_jumps();
    drive(0, 0, 1, 3'd0, 32'h1001, 32'h0, 32'h300, 32'h2, 1'b1, 32'h1002);
    step(); valid_i = 1'b0;
    if (target_o !== 32'h1002) begin n_fail++; $display("FAIL jalr_target: got %08h want 00001002", target_o); end n_checks++;
    if (taken_o !== 1'b1) begin n_fail++; $display("FAIL jalr_taken: got %0h want 1", taken_o); end n_checks++;
    if (mispredict_o !== 1'b0) begin n_fail++; $display("FAIL jalr_mispred0: got %0h want 0", mispredict_o); end n_checks++;
    $display("jalr: target=%08h mispred=%0h", target_o, mispredict_o);
    drive(0, 0, 1, 3'd0, 32'h1001, 32'h0, 32'h300, 32'h2, 1'b1, 32'h1000);
    step(); valid_i = 1'b0;
    if (mispredict_o !== 1'b1) begin n_fail++; $display("FAIL jalr_mispred1: got %0h want 1", mispredict_o); end n_checks++;
    if (redirect_pc_o !== 32'h1002) begin n_fail++; $display("FAIL jalr_redirect: got %08h want 00001002", redirect_pc_o); end n_checks++;
    $display("jalr: target=%08h mispred=%0h", target_o, mispredict_o);
    // JAL with a negative offset
    drive(0, 1, 0, 3'd0, 32'h0, 32'h0, 32'h200, 32'hFFFF_FFF8, 1'b1, 32'h1F8);
    step(); valid_i = 1'b0;
    if (target_o !== 32'h1F8) begin n_fail++; $display("FAIL jal_target: got %08h want 000001f8", target_o); end n_checks++;
    if (mispredict_o !== 1'b0) begin n_fail++; $display("FAIL jal_mispred: got %0h want 0", mispredict_o); end n_checks++;
    $display("jal: target=%08h mispred=%0h", target_o, mispredict_o);
    // JALR wins over JAL and branch when several flags are set
    drive(1, 1, 1, 3'd0, 32'h2000, 32'h2000, 32'h400, 32'h10, 1'b1, 32'h0);
    step(); valid_i = 1'b0;
    if (target_o !== 32'h2010) begin n_fail++; $display("FAIL prio_target: got %08h want 00002010", target_o); end n_checks++;
    $display("prio: target=%08h", target_o);
    // No instruction class: not taken, mispredict mirrors the prediction
    drive(0, 0, 0, 3'd0, 32'h0, 32'h0, 32'h500, 32'h10, 1'b1, 32'h510);
    step(); valid_i = 1'b0;
    if (valid_o !== 1'b1) begin n_fail++; $display("FAIL none_valid: got %0h want 1", valid_o); end n_checks++;
    if (taken_o !== 1'b0) begin n_fail++; $display("FAIL none_taken: got %0h want 0", taken_o); end n_checks++;
    if (mispredict_o !== 1'b1) begin n_fail++; $display("FAIL none_mispred: got %0h want 1", mispredict_o); end n_checks++;
    if (redirect_pc_o !== 32'h504) begin n_fail++; $display("FAIL none_redirect: got %08h want 00000504", redirect_pc_o); end n_checks++;
    $display("none: taken=%0h mispred=%0h redirect=%08h", taken_o, mispredict_o, redirect_pc_o);
    step();
    if (valid_o !== 1'b0) begin n_fail++; $display("FAIL drain_valid: got %0h want 0", valid_o); end n_checks++;
  endtask

  task automatic test_bht_saturation();
    do_reset();
    lookup_pc_i = 32'h40;
    #1;
    if (pred_taken_o !== 1'b0) begin n_fail++; $display("FAIL bht_init: got %0h want 0", pred_taken_o); end n_checks++;
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 3'd0, 32'h5, 32'h5, 32'h40, 32'h8, 1'b0, 32'h0);
      if (i == 0) begin
        // Counter is 01 before the first update edge
        if (pred_taken_o !== 1'b0) begin n_fail++; $display("FAIL bht_rbw: got %0h want 0", pred_taken_o); end n_checks++;
      end
      step();
      $display("bht taken #%0d: pred=%0h", i, pred_taken_o);
    end
    valid_i = 1'b0;
    if (pred_taken_o !== 1'b1) begin n_fail++; $display("FAIL bht_sat_hi: got %0h want 1", pred_taken_o); end n_checks++;
    drive(1, 0, 0, 3'd0, 32'h5, 32'h6, 32'h40, 32'h8, 1'b0, 32'h0);
    step(); valid_i = 1'b0;
    if (pred_taken_o !== 1'b1) begin n_fail++; $display("FAIL bht_nt1: got %0h want 1", pred_taken_o); end n_checks++;
    $display("bht not-taken #0: pred=%0h", pred_taken_o);
    drive(1, 0, 0, 3'd0, 32'h5, 32'h6, 32'h40, 32'h8, 1'b0, 32'h0);
    step(); valid_i = 1'b0;
    if (pred_taken_o !== 1'b0) begin n_fail++; $display("FAIL bht_nt2: got %0h want 0", pred_taken_o); end n_checks++;
    $display("bht not-taken #1: pred=%0h", pred_taken_o);
    lookup_pc_i = 32'h44;
    #1;
    if (pred_taken_o !== 1'b0) begin n_fail++; $display("FAIL bht_other: got %0h want 0", pred_taken_o); end n_checks++;
    lookup_pc_i = 32'h40;
    step();
  endtask

  task automatic test_back_to_back();
    ready_i = 1'b1;
    drive(1, 0, 0, 3'd0, 32'h9, 32'h9, 32'h300, 32'h10, 1'b1, 32'h310);
    step();
    ready_i = 1'b0;
    drive(0, 1, 0, 3'd0, 32'h0, 32'h0, 32'h400, 32'h40, 1'b1, 32'h440);
    #1;
    if (ready_o !== 1'b0) begin n_fail++; $display("FAIL bp_ready: got %0h want 0", ready_o); end n_checks++;
    for (int i = 0; i < 5; i++) begin
      step();
      if (valid_o !== 1'b1 || target_o !== 32'h310) begin
        n_fail++; $display("FAIL bp_hold%0d: got valid=%0h target=%08h want valid=1 target=00000310", i, valid_o, target_o);
      end
      n_checks++;
      $display("bp hold %0d: valid=%0h target=%08h", i, valid_o, target_o);
    end
    ready_i = 1'b1;
    #1;
    if (ready_o !== 1'b1) begin n_fail++; $display("FAIL bp_ready_up: got %0h want 1", ready_o); end n_checks++;
    step(); valid_i = 1'b0;
    if (valid_o !== 1'b1 || target_o !== 32'h440) begin
      n_fail++; $display("FAIL bp_second: got valid=%0h target=%08h want valid=1 target=00000440", valid_o, target_o);
    end
    n_checks++;
    $display("bp second: valid=%0h target=%08h", valid_o, target_o);
    step();
    if (valid_o !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got %0h want 0", valid_o); end n_checks++;
  endtask

  task automatic test_flush_illegal();
    // Index of pc 0x40 holds 01 after the saturation test
    lookup_pc_i = 32'h40;
    drive(0, 1, 0, 3'd0, 32'h0, 32'h0, 32'h600, 32'h4, 1'b1, 32'h604);
    step();
    drive(1, 0, 0, 3'd0, 32'h7, 32'h7, 32'h40, 32'h8, 1'b0, 32'h0);
    flush_i = 1'b1;
    step(); flush_i = 1'b0; valid_i = 1'b0;
    if (valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %0h want 0", valid_o); end n_checks++;
    if (pred_taken_o !== 1'b0) begin n_fail++; $display("FAIL flush_bht: got %0h want 0", pred_taken_o); end n_checks++;
    $display("flush: valid=%0h pred=%0h", valid_o, pred_taken_o);
    drive(1, 0, 0, 3'd3, 32'h7, 32'h7, 32'h40, 32'h8, 1'b0, 32'h0);
    step(); valid_i = 1'b0;
    if (illegal_o !== 1'b1) begin n_fail++; $display("FAIL ill_flag: got %0h want 1", illegal_o); end n_checks++;
    if (taken_o !== 1'b0) begin n_fail++; $display("FAIL ill_taken: got %0h want 0", taken_o); end n_checks++;
    if (pred_taken_o !== 1'b0) begin n_fail++; $display("FAIL ill_bht: got %0h want 0", pred_taken_o); end n_checks++;
    $display("illegal: illegal=%0h taken=%0h pred=%0h", illegal_o, taken_o, pred_taken_o);
    // A legal taken branch at the same PC does move the counter to 10
    drive(1, 0, 0, 3'd0, 32'h7, 32'h7, 32'h40, 32'h8, 1'b0, 32'h0);
    step(); valid_i = 1'b0;
    if (illegal_o !== 1'b0) begin n_fail++; $display("FAIL legal_flag: got %0h want 0", illegal_o); end n_checks++;
    if (pred_taken_o !== 1'b1) begin n_fail++; $display("FAIL legal_bht: got %0h want 1", pred_taken_o); end n_checks++;
    $display("legal: illegal=%0h pred=%0h", illegal_o, pred_taken_o);
    step();
  endtask

  task automatic test_stats();
    do_reset();
    drive(1, 0, 0, 3'd0, 32'h7, 32'h7, 32'h500, 32'h8, 1'b1, 32'h508);   // taken, correct
    step();
    drive(1, 0, 0, 3'd1, 32'h7, 32'h7, 32'h504, 32'h8, 1'b0, 32'h0);     // not taken, correct
    step();
    drive(1, 0, 0, 3'd4, 32'h1, 32'h2, 32'h600, 32'h10, 1'b0, 32'h0);    // taken, mispredicted
    step();
    drive(0, 1, 0, 3'd0, 32'h0, 32'h0, 32'h700, 32'h4, 1'b1, 32'h704);   // JAL, correct
    step(); valid_i = 1'b0;
    step();
`ifdef BRU_STATS_EN
    if (stat_branches_o !== 32'd3) begin n_fail++; $display("FAIL stat_br: got %0d want 3", stat_branches_o); end n_checks++;
    if (stat_mispred_o !== 32'd1) begin n_fail++; $display("FAIL stat_mp: got %0d want 1", stat_mispred_o); end n_checks++;
`else
    if (stat_branches_o !== 32'd0) begin n_fail++; $display("FAIL stat_br_off: got %0d want 0", stat_branches_o); end n_checks++;
    if (stat_mispred_o !== 32'd0) begin n_fail++; $display("FAIL stat_mp_off: got %0d want 0", stat_mispred_o); end n_checks++;
`endif
    $display("stats: branches=%0d mispred=%0d", stat_branches_o, stat_mispred_o);
    // Reset while a result is held
    drive(1, 0, 0, 3'd4, 32'h1, 32'h2, 32'h600, 32'h10, 1'b0, 32'h0);
    step(); valid_i = 1'b0;
    rst_i = 1'b1;
    step(); rst_i = 1'b0;
    if (valid_o !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %0h want 0", valid_o); end n_checks++;
    if (stat_branches_o !== 32'd0) begin n_fail++; $display("FAIL midrst_br: got %0d want 0", stat_branches_o); end n_checks++;
    if (stat_mispred_o !== 32'd0) begin n_fail++; $display("FAIL midrst_mp: got %0d want 0", stat_mispred_o); end n_checks++;
    $display("mid reset: valid=%0h branches=%0d mispred=%0d", valid_o, stat_branches_o, stat_mispred_o);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #2;
    test_reset();
    test_branch_cond();
    test_jumps();
    test_bht_saturation();
    test_back_to_back();
    test_flush_illegal();
    test_stats();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Resolves conditional branches, JAL and JALR for the execute stage, one instruction per accepted handshake.
- Adds a registered output stage with a valid/ready handshake.
- Holds a 2-bit saturating branch history table (BHT) that fetch queries for direction predictions.
- Reports misprediction and the redirect PC to the front end.

Parameters:
- N, 32, operand/PC/immediate width.
- BHT_DEPTH, 64, BHT entries; power of 2, minimum 2.
- BHT_INIT, 2'b01, reset value of every BHT counter (weakly not-taken).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- flush_i  in  1  pipeline flush; discards the output register and any input this cycle.
- valid_i  in  1  input instruction valid.
- ready_o  out  1  unit can accept an input.
- is_branch_i  in  1  conditional branch.
- is_jal_i  in  1  JAL.
- is_jalr_i  in  1  JALR.
- funct3_i  in  3  branch condition code.
- data1_i  in  N  rs1 value.
- data2_i  in  N  rs2 value.
- pc_i  in  N  instruction PC.
- imm_i  in  N  sign-extended immediate.
- pred_taken_i  in  1  direction fetch used.
- pred_target_i  in  N  target fetch used.
- lookup_pc_i  in  N  fetch-side BHT query PC.
- pred_taken_o  out  1  BHT prediction for lookup_pc_i (combinational).
- valid_o  out  1  result valid.
- ready_i  in  1  consumer ready.
- taken_o  out  1  resolved direction.
- target_o  out  N  resolved target.
- mispredict_o  out  1  prediction wrong.
- redirect_pc_o  out  N  correct next PC.
- illegal_o  out  1  funct3 2 or 3 on a branch.
- stat_branches_o  out  32  resolved conditional branches (see Optional Feature).
- stat_mispred_o  out  32  mispredicted instructions (see Optional Feature).

Behaviour:
- Interface: one clock clk_i; reset rst_i is synchronous and active-high.
- Reset: valid_o and all result outputs are 0, every BHT entry is BHT_INIT, and stat counters are 0.
- Handshake: ready_o = ~valid_o | ready_i. An input is accepted when valid_i & ready_o & ~flush_i. The output fires when valid_o & ready_i.
- Latency: results are registered and appear on valid_o in the cycle after acceptance. Outputs hold stable while valid_o & ~ready_i.
- Priority: rst_i > flush_i > accept. flush_i clears valid_o next cycle, does not update the BHT, and drops any input presented that cycle.
- Conditions (funct3_i): 0 EQ, 1 NE, 4 signed LT, 5 signed GE, 6 unsigned LT, 7 unsigned GE. Codes 2 and 3 give taken=0 and illegal_o=1.
- Comparison uses a full N-bit signed or unsigned compare; the MSB is handled correctly (e.g. 0x80000000 < 0 when signed, > 0 when unsigned).
- Targets:
  - Branch and JAL: pc_i + imm_i, mod 2^N.
  - JALR: (data1_i + imm_i) & ~1.
  - JAL and JALR are always taken.
- redirect_pc_o = taken ? target : pc_i + 4.
- mispredict_o = (taken != pred_taken_i) | (taken & (target != pred_target_i)).
- If none of the is_* inputs is set: taken=0, mispredict_o = pred_taken_i, and valid_o is still produced.
- More than one is_* set: priority is JALR > JAL > branch.
- BHT index = pc[log2(BHT_DEPTH)+1:2]; the same index is used for lookup_pc_i. Prediction = counter[1].
- BHT update happens at accept, for conditional branches only (not illegal ones). Counters saturate at 00 and 11: taken increments, not-taken decrements.
- Same-cycle lookup and update to the same index return the pre-update value (read-before-write).
- Reset mid-operation discards any in-flight result; no output fires.

Optional Feature:
- Macro BRU_STATS_EN.
- Defined:
  - stat_branches_o increments on each output fire of a non-illegal conditional branch.
  - stat_mispred_o increments on each output fire with mispredict_o=1.
  - Both are 32-bit, saturate at 0xFFFFFFFF, are cleared by rst_i, and are unaffected by flush_i.
- Undefined: the counter logic is absent and both ports are tied to 0.

Test Plan:
- BLT signed, data1=0xFFFFFFFF, data2=1, pc=0x100, imm=0x20, pred_taken=0 -> next cycle valid_o=1, taken=1, target=0x120, mispredict=1, redirect=0x120. BLTU with the same operands -> taken=0, redirect=0x104.
- JALR, data1=0x1001, imm=2, pred_taken=1, pred_target=0x1002 -> target=0x1002, mispredict=0. Repeat with pred_target=0x1000 -> mispredict=1.
- BHT saturation: after reset, lookup pc=0x40 gives pred_taken_o=0. Four taken BEQ at pc=0x40 -> counter 11, pred_taken_o=1. One not-taken -> still 1. Second not-taken -> 0.
- Backpressure: ready_i=0 with valid_o=1 -> ready_o=0, outputs stable for 5 cycles, the second input is not accepted. Raise ready_i -> fire, then the second result appears 1 cycle later.
- flush_i asserted with valid_i=1 and valid_o=1 -> next cycle valid_o=0, BHT unchanged. funct3=3 branch -> illegal_o=1, taken=0, BHT unchanged.
- With BRU_STATS_EN: 3 branches, one mispredicted, plus 1 JAL -> stat_branches_o=3, stat_mispred_o=1. rst_i mid-stream -> both 0 and valid_o=0.
